// File: rtl/ram_pkg.sv
// Shared op codes, access-size codes and FSM state encoding for the ram_bus block.
package ram_pkg;

  localparam logic [1:0] RAM_NOP   = 2'd0;
  localparam logic [1:0] RAM_READ  = 2'd1;
  localparam logic [1:0] RAM_WRITE = 2'd2;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_RSVD = 2'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BEAT2 = 1'b1
  } ram_state_e;

  // Number of bytes touched by an access; the reserved code maps to zero.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_bytes = 3'd1;
      SIZE_HALF: size_bytes = 3'd2;
      SIZE_WORD: size_bytes = 3'd4;
      default:   size_bytes = 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/ram_lane.sv
// One byte lane: single-port memory with synchronous read; rdata holds between reads.
module ram_lane #(
  parameter int ROWS  = 16384,
  parameter int ROW_W = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [ROW_W-1:0] row,
  input  logic [7:0]       wdata,
  output logic [7:0]       rdata
);

  logic [7:0] mem [ROWS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[row] <= wdata;
      else    rdata    <= mem[row];
    end
  end

endmodule

// File: rtl/ram_bus.sv
// Big-endian byte-addressable RAM on four byte lanes; row-crossing accesses
// are split into two beats, everything else completes in one cycle.
module ram_bus
  import ram_pkg::*;
#(
  parameter int MEM_SIZE = 65536,
  parameter int ADDR_W   = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_do,
  input  logic [1:0]        i_size,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_val,
  output logic              o_ready,
  output logic              o_valid,
  output logic [31:0]       o_val,
  output logic              o_err,
  output ram_state_e        dbg_state
);

  localparam int ROWS  = MEM_SIZE / 4;
  localparam int ROW_W = $clog2(ROWS);

  // Handshake: a request transfers on a rising edge where o_ready=1 and i_do is
  // READ or WRITE; the requester holds it otherwise. Every transfer yields exactly
  // one o_valid pulse (unless reset intervenes); o_val/o_err are zero without it.

  ram_state_e state, state_next;

  logic [2:0]      in_n;
  logic [ADDR_W:0] end_addr;
  logic            in_access, in_err, in_cross, accept, go;

  logic [1:0]       req_off, req_size;
  logic [ROW_W-1:0] req_row;
  logic [31:0]      req_val;
  logic             req_wr;

  logic [1:0]       cur_off;
  logic [2:0]       cur_n, req_n;
  logic [ROW_W-1:0] cur_row;
  logic [31:0]      cur_val;
  logic             cur_wr, cur_act, beat2;

  logic [3:0] lane_en, lane_we;
  logic [1:0] lane_k     [4];
  logic [2:0] lane_idx   [4];
  logic [7:0] lane_wdata [4];
  logic [7:0] lane_rdata [4];

  logic        valid_q, err_q;
  logic [31:0] rd_val;

  // Request decode
  always_comb begin
    in_n      = size_bytes(i_size);
    in_access = (i_do == RAM_READ) || (i_do == RAM_WRITE);
    end_addr  = {1'b0, i_addr} + (ADDR_W + 1)'(in_n) - (ADDR_W + 1)'(1);
    in_err    = (i_size == SIZE_RSVD) || (end_addr >= (ADDR_W + 1)'(MEM_SIZE));
    in_cross  = ({1'b0, i_addr[1:0]} + in_n) > 3'd4;
    accept    = (state == ST_IDLE) && in_access;
    go        = accept && !in_err && !i_rst;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (go && in_cross) state_next = ST_BEAT2;
      ST_BEAT2: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_next;
  end

  // First beat steers straight from the inputs; the second beat from held registers.
  always_comb begin
    beat2   = (state == ST_BEAT2);
    cur_off = beat2 ? req_off : i_addr[1:0];
    cur_n   = beat2 ? size_bytes(req_size) : in_n;
    cur_row = beat2 ? req_row : i_addr[ROW_W+1:2];
    cur_val = beat2 ? req_val : i_val;
    cur_wr  = beat2 ? req_wr  : (i_do == RAM_WRITE);
    cur_act = beat2 ? !i_rst  : go;
  end

  // Lane l carries access byte k = l - off; lanes below off belong to the next row.
  always_comb begin
    for (int l = 0; l < 4; l++) begin
      lane_k[l]     = 2'(l) - cur_off;
      lane_idx[l]   = cur_n - 3'd1 - {1'b0, lane_k[l]};
      lane_en[l]    = cur_act && ({1'b0, lane_k[l]} < cur_n) && ((2'(l) >= cur_off) != beat2);
      lane_we[l]    = lane_en[l] && cur_wr;
      lane_wdata[l] = 8'(cur_val >> {lane_idx[l], 3'b000});
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_lane
    ram_lane #(
      .ROWS (ROWS),
      .ROW_W(ROW_W)
    ) u_lane (
      .clk  (i_clk),
      .en   (lane_en[g]),
      .we   (lane_we[g]),
      .row  (cur_row),
      .wdata(lane_wdata[g]),
      .rdata(lane_rdata[g])
    );
  end

  always_ff @(posedge i_clk) begin
    if (accept && !i_rst) begin
      req_off  <= i_addr[1:0];
      req_size <= i_size;
      req_row  <= i_addr[ROW_W+1:2] + ROW_W'(1);
      req_val  <= i_val;
      req_wr   <= (i_do == RAM_WRITE);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      if (accept) begin
        if (in_err) begin
          valid_q <= 1'b1;
          err_q   <= 1'b1;
        end else if (!in_cross) begin
          valid_q <= 1'b1;
        end
      end else if (beat2) begin
        valid_q <= 1'b1;
      end
    end
  end

  // Byte k of the access is value byte n-1-k (big-endian).
  always_comb begin
    req_n  = size_bytes(req_size);
    rd_val = '0;
    for (int k = 0; k < 4; k++) begin
      if (k < int'(req_n))
        rd_val = rd_val | (32'(lane_rdata[2'(int'(req_off) + k)]) << (8 * (int'(req_n) - 1 - k)));
    end
  end

  assign o_ready   = (state == ST_IDLE);
  assign o_valid   = valid_q;
  assign o_err     = err_q;
  assign o_val     = (valid_q && !err_q && !req_wr) ? rd_val : 32'h0;
  assign dbg_state = state;

endmodule
